// File: rtl/s_trap_if.sv
// Trap-request, SRET strobe and fetch-redirect bundle between pipeline/fetch and s_trap_ctrl.
// master = pipeline/fetch side, slave = trap controller.
interface s_trap_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CAUSE_W = 5
);
  logic               trap_req;
  logic               trap_is_irq;
  logic [CAUSE_W-1:0] trap_cause;
  logic [XLEN-1:0]    trap_tval;
  logic [XLEN-1:0]    trap_pc;
  logic               trap_ack;
  logic               sret_pulse;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               redirect_ready;

  modport master (
    output trap_req, trap_is_irq, trap_cause, trap_tval, trap_pc, sret_pulse, redirect_ready,
    input  trap_ack, redirect_valid, redirect_pc
  );

  modport slave (
    input  trap_req, trap_is_irq, trap_cause, trap_tval, trap_pc, sret_pulse, redirect_ready,
    output trap_ack, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/s_trap_ctrl.sv
// Supervisor trap sequencer: S-mode trap entry, SRET return and fetch redirect handshake.
// Optional macro HARVOS_STVEC_VECTORED_EN enables vectored stvec for interrupts.
module s_trap_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CAUSE_W    = 5,
  parameter logic [1:0]  RESET_PRIV = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  s_trap_if.slave         bus,
  input  logic [XLEN-1:0] i_stvec,
  input  logic            i_csr_we,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [1:0]      o_cur_priv,
  output logic [XLEN-1:0] o_sepc,
  output logic [XLEN-1:0] o_scause,
  output logic [XLEN-1:0] o_stval,
  output logic            o_sstatus_sie,
  output logic            o_sstatus_spie,
  output logic            o_sstatus_spp,
  output logic            o_busy
);

  localparam logic [1:0]  PRIV_U      = 2'b00;
  localparam logic [1:0]  PRIV_S      = 2'b01;
  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam int unsigned PAD_W       = XLEN - 1 - CAUSE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    T_SAVE  = 2'd1,
    T_REDIR = 2'd2,
    R_REDIR = 2'd3
  } state_t;

  state_t             r_state;
  logic [1:0]         r_priv;
  logic [XLEN-1:0]    r_sepc;
  logic [XLEN-1:0]    r_scause;
  logic [XLEN-1:0]    r_stval;
  logic               r_sie;
  logic               r_spie;
  logic               r_spp;
  logic               r_redirect_valid;
  logic [XLEN-1:0]    r_redirect_pc;
  logic               r_irq;
  logic [CAUSE_W-1:0] r_cause;
  logic [XLEN-1:0]    r_tval;
  logic [XLEN-1:0]    r_epc;

  logic               w_wr_sstatus;
  logic               w_wr_sepc;
  logic [XLEN-1:0]    w_base_pc;
  logic [XLEN-1:0]    w_entry_pc;
  logic               w_unused;

  assign w_wr_sstatus = i_csr_we && (i_csr_addr == CSR_SSTATUS);
  assign w_wr_sepc    = i_csr_we && (i_csr_addr == CSR_SEPC);
  assign w_base_pc    = {i_stvec[XLEN-1:2], 2'b00};

`ifdef HARVOS_STVEC_VECTORED_EN
  // Vectored mode only offsets interrupts; exceptions always land on the base.
  assign w_entry_pc = ((i_stvec[1:0] == 2'b01) && r_irq)
                      ? (w_base_pc + (XLEN'(r_cause) << 2))
                      : w_base_pc;
  assign w_unused   = ^{i_csr_wdata[0], bus.trap_pc[1:0]};
`else
  assign w_entry_pc = w_base_pc;
  assign w_unused   = ^{i_csr_wdata[0], bus.trap_pc[1:0], i_stvec[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_priv           <= RESET_PRIV;
      r_sepc           <= '0;
      r_scause         <= '0;
      r_stval          <= '0;
      r_sie            <= 1'b0;
      r_spie           <= 1'b0;
      r_spp            <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_irq            <= 1'b0;
      r_cause          <= '0;
      r_tval           <= '0;
      r_epc            <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.trap_req) begin
            r_state <= T_SAVE;
            r_irq   <= bus.trap_is_irq;
            r_cause <= bus.trap_cause;
            r_tval  <= bus.trap_tval;
            r_epc   <= {bus.trap_pc[XLEN-1:2], 2'b00};
          end else if (bus.sret_pulse) begin
            r_state          <= R_REDIR;
            r_sie            <= r_spie;
            r_spie           <= 1'b1;
            r_priv           <= r_spp ? PRIV_S : PRIV_U;
            r_spp            <= 1'b0;
            r_redirect_pc    <= r_sepc;
            r_redirect_valid <= 1'b1;
          end
          // Software writes come last so they override the SRET sstatus update.
          if (w_wr_sstatus) begin
            r_sie  <= i_csr_wdata[1];
            r_spie <= i_csr_wdata[5];
            r_spp  <= i_csr_wdata[8];
          end
          if (w_wr_sepc) begin
            r_sepc <= {i_csr_wdata[XLEN-1:2], 2'b00};
          end
        end
        T_SAVE: begin
          r_sepc           <= r_epc;
          r_scause         <= {r_irq, {PAD_W{1'b0}}, r_cause};
          r_stval          <= r_tval;
          r_spie           <= r_sie;
          r_sie            <= 1'b0;
          r_spp            <= (r_priv == PRIV_S);
          r_priv           <= PRIV_S;
          r_redirect_pc    <= w_entry_pc;
          r_redirect_valid <= 1'b1;
          r_state          <= T_REDIR;
        end
        T_REDIR, R_REDIR: begin
          if (bus.redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_state          <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.trap_ack       = (r_state == IDLE) && bus.trap_req;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;

  assign o_cur_priv     = r_priv;
  assign o_sepc         = r_sepc;
  assign o_scause       = r_scause;
  assign o_stval        = r_stval;
  assign o_sstatus_sie  = r_sie;
  assign o_sstatus_spie = r_spie;
  assign o_sstatus_spp  = r_spp;
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_s_trap_ctrl.sv
// Directed bench for s_trap_ctrl: expected redirect targets queued at stimulus, popped at handshake.
module tb_s_trap_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] stvec;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  cur_priv;
  logic [31:0] sepc;
  logic [31:0] scause;
  logic [31:0] stval;
  logic        sie;
  logic        spie;
  logic        spp;
  logic        busy;

  int          n_checks;
  int          n_err;
  logic [31:0] exp_q[$];

`ifdef HARVOS_STVEC_VECTORED_EN
  localparam logic [31:0] VEC_EXP = 32'h8000_0114;
`else
  localparam logic [31:0] VEC_EXP = 32'h8000_0100;
`endif

  s_trap_if #(.XLEN(32), .CAUSE_W(5)) bus ();

  s_trap_ctrl #(.XLEN(32), .CAUSE_W(5), .RESET_PRIV(2'b01)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .i_stvec        (stvec),
    .i_csr_we       (csr_we),
    .i_csr_addr     (csr_addr),
    .i_csr_wdata    (csr_wdata),
    .o_cur_priv     (cur_priv),
    .o_sepc         (sepc),
    .o_scause       (scause),
    .o_stval        (stval),
    .o_sstatus_sie  (sie),
    .o_sstatus_spie (spie),
    .o_sstatus_spp  (spp),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, input int exp_lat);
    int n;
    n = 0;
    while (bus.redirect_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.redirect_valid), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  // Hold ready low for `stall` cycles, then complete the handshake against the scoreboard.
  task automatic finish_redirect(input string tag, input int stall);
    logic [31:0] e;
    chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_valid"}, 32'(bus.redirect_valid), 32'd1);
      chk({tag, "_stall_pc"}, bus.redirect_pc, e);
      tick();
    end
    bus.redirect_ready = 1'b1;
    chk({tag, "_hs_valid"}, 32'(bus.redirect_valid), 32'd1);
    chk({tag, "_hs_pc"}, bus.redirect_pc, e);
    tick();
    bus.redirect_ready = 1'b0;
    chk({tag, "_drop"}, 32'(bus.redirect_valid), 32'd0);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    stvec = 32'h8000_0100;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    bus.trap_req = 1'b0; bus.trap_is_irq = 1'b0; bus.trap_cause = '0;
    bus.trap_tval = '0; bus.trap_pc = '0; bus.sret_pulse = 1'b0; bus.redirect_ready = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_priv", 32'(cur_priv), 32'h1);
    chk("rst_sepc", sepc, 32'h0);
    chk("rst_scause", scause, 32'h0);
    chk("rst_stval", stval, 32'h0);
    chk("rst_sstatus", 32'({sie, spie, spp}), 32'h0);
    chk("rst_valid", 32'(bus.redirect_valid), 32'h0);
    chk("rst_rpc", bus.redirect_pc, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // SRET from S with spp=0, spie=1; ready held low 3 cycles
    csr_write(12'h100, 32'h0000_0020);
    csr_write(12'h141, 32'h0000_2003);
    chk("csr_spie", 32'(spie), 32'h1);
    chk("csr_sie", 32'(sie), 32'h0);
    chk("csr_sepc_align", sepc, 32'h0000_2000);
    bus.sret_pulse = 1'b1;
    exp_q.push_back(32'h0000_2000);
    tick();
    bus.sret_pulse = 1'b0;
    wait_valid("sret", 8, 0);
    chk("sret_priv", 32'(cur_priv), 32'h0);
    chk("sret_sie", 32'(sie), 32'h1);
    chk("sret_spie", 32'(spie), 32'h1);
    chk("sret_spp", 32'(spp), 32'h0);
    chk("sret_busy", 32'(busy), 32'h1);
    // Trap and SRET while busy must be ignored
    bus.trap_req = 1'b1; bus.sret_pulse = 1'b1;
    #1;
    chk("busy_ack", 32'(bus.trap_ack), 32'h0);
    tick();
    bus.trap_req = 1'b0; bus.sret_pulse = 1'b0;
    finish_redirect("sret", 2);
    chk("sret_idle", 32'(busy), 32'h0);
    chk("sret_q_empty", 32'(exp_q.size()), 32'h0);

    // U-mode ecall
    bus.trap_req = 1'b1; bus.trap_is_irq = 1'b0; bus.trap_cause = 5'd8;
    bus.trap_pc = 32'h0000_1006; bus.trap_tval = 32'h0;
    exp_q.push_back(32'h8000_0100);
    #1;
    chk("ecall_ack", 32'(bus.trap_ack), 32'h1);
    tick();
    #1;
    chk("ecall_ack_tsave", 32'(bus.trap_ack), 32'h0);
    bus.trap_req = 1'b0;
    wait_valid("ecall", 8, 1);
    chk("ecall_sepc", sepc, 32'h0000_1004);
    chk("ecall_scause", scause, 32'h0000_0008);
    chk("ecall_stval", stval, 32'h0);
    chk("ecall_spp", 32'(spp), 32'h0);
    chk("ecall_priv", 32'(cur_priv), 32'h1);
    chk("ecall_sie", 32'(sie), 32'h0);
    chk("ecall_spie", 32'(spie), 32'h1);
    finish_redirect("ecall", 0);

    // Trap + SRET + sstatus write (sie=1) in the same cycle: trap wins, T_SAVE sees new sie
    bus.trap_req = 1'b1; bus.trap_is_irq = 1'b0; bus.trap_cause = 5'd2;
    bus.trap_pc = 32'h0000_3000; bus.trap_tval = 32'hDEAD_BEEF;
    bus.sret_pulse = 1'b1;
    csr_we = 1'b1; csr_addr = 12'h100; csr_wdata = 32'h0000_0002;
    exp_q.push_back(32'h8000_0100);
    #1;
    chk("coll_ack", 32'(bus.trap_ack), 32'h1);
    tick();
    bus.trap_req = 1'b0; bus.sret_pulse = 1'b0; csr_we = 1'b0;
    wait_valid("coll", 8, 1);
    chk("coll_sie", 32'(sie), 32'h0);
    chk("coll_spie", 32'(spie), 32'h1);
    chk("coll_spp", 32'(spp), 32'h1);
    chk("coll_priv", 32'(cur_priv), 32'h1);
    chk("coll_sepc", sepc, 32'h0000_3000);
    chk("coll_scause", scause, 32'h0000_0002);
    chk("coll_stval", stval, 32'hDEAD_BEEF);
    finish_redirect("coll", 1);
    chk("coll_q_empty", 32'(exp_q.size()), 32'h0);
    tick();
    chk("coll_no_sret", 32'(bus.redirect_valid), 32'h0);
    chk("coll_idle", 32'(busy), 32'h0);

    // Interrupt with stvec MODE=01; sepc write while busy is dropped
    stvec = 32'h8000_0101;
    bus.trap_req = 1'b1; bus.trap_is_irq = 1'b1; bus.trap_cause = 5'd5;
    bus.trap_pc = 32'h0000_4000; bus.trap_tval = 32'h0;
    exp_q.push_back(VEC_EXP);
    #1;
    chk("irq_ack", 32'(bus.trap_ack), 32'h1);
    tick();
    bus.trap_req = 1'b0; bus.trap_is_irq = 1'b0;
    wait_valid("irq", 8, 1);
    chk("irq_scause", scause, 32'h8000_0005);
    csr_write(12'h141, 32'h0000_5555);
    finish_redirect("irq", 1);
    chk("irq_sepc_kept", sepc, 32'h0000_4000);

    // Reset in the middle of a return redirect
    csr_write(12'h100, 32'h0);
    bus.sret_pulse = 1'b1;
    exp_q.push_back(32'h0000_4000);
    tick();
    bus.sret_pulse = 1'b0;
    wait_valid("mid", 8, 0);
    chk("mid_priv_u", 32'(cur_priv), 32'h0);
    chk("mid_pc", bus.redirect_pc, exp_q.pop_front());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 32'(bus.redirect_valid), 32'h0);
    chk("mid_rpc", bus.redirect_pc, 32'h0);
    chk("mid_priv", 32'(cur_priv), 32'h1);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_sepc", sepc, 32'h0);
    tick();
    chk("mid_stay_idle", 32'(bus.redirect_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
